// File: rtl/kfps2kb_keycode_fifo.sv
// rtl/kfps2kb_keycode_fifo.sv - XT keycode FIFO between the PS/2 controller and PPI port A / IRQ1
// Captures upstream bytes with back-pressure and delivers them one at a time; PB6 hold injects 0xAA.
module kfps2kb_keycode_fifo #(
  parameter int          DEPTH_LOG2 = 3,
  parameter logic [19:0] RESET_HOLD = 20'd100000,
  parameter logic [7:0]  GAP_CYCLES = 8'd16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       kb_irq,
  input  logic [7:0] kb_keycode,
  output logic       kb_clear,
  input  logic       kbd_clock_low,
  input  logic       clear_keycode,
  output logic       irq,
  output logic [7:0] keycode,
  output logic       fifo_full,
  output logic       fifo_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {CAP_IDLE, CAP_ACK, CAP_WAIT} cap_state_t;
  typedef enum logic {OUT_IDLE, OUT_HOLD} out_state_t;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [19:0]           hold_cnt;
  logic [7:0]            gap_cnt;
  cap_state_t            cap_state;
  out_state_t            out_state;

  logic inject;
  logic push;
  logic pop;

  assign fifo_full  = (count == FULL_COUNT);
  assign fifo_empty = (count == '0);

  // A nonzero hold count means kbd_clock_low was high last cycle, so this is its falling edge.
  always_comb begin
    inject = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    inject = !kbd_clock_low && (hold_cnt != 20'd0) && (hold_cnt == RESET_HOLD);
    push   = (cap_state == CAP_IDLE) && kb_irq && !fifo_full && !kbd_clock_low && !inject;
    pop    = (out_state == OUT_IDLE) && !fifo_empty && !kbd_clock_low &&
             (gap_cnt == 8'd0) && !inject;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (inject) begin
        mem[0] <= 8'hAA;
      end else if (push) begin
        mem[wr_ptr] <= kb_keycode;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (inject) begin
      wr_ptr <= DEPTH_LOG2'(1);
      rd_ptr <= '0;
      count  <= (DEPTH_LOG2 + 1)'(1);
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cap_state <= CAP_IDLE;
      kb_clear  <= 1'b0;
    end else begin
      case (cap_state)
        CAP_IDLE: begin
          kb_clear <= push;
          if (push) cap_state <= CAP_ACK;
        end
        CAP_ACK: begin
          kb_clear  <= 1'b0;
          cap_state <= CAP_WAIT;
        end
        CAP_WAIT: begin
          // Upstream needs a cycle to drop kb_irq after seeing kb_clear.
          kb_clear  <= 1'b0;
          cap_state <= CAP_IDLE;
        end
        default: begin
          kb_clear  <= 1'b0;
          cap_state <= CAP_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_state <= OUT_IDLE;
      irq       <= 1'b0;
      keycode   <= 8'h00;
      gap_cnt   <= 8'd0;
    end else if (inject) begin
      out_state <= OUT_IDLE;
      irq       <= 1'b0;
      keycode   <= 8'h00;
      gap_cnt   <= 8'd0;
    end else begin
      case (out_state)
        OUT_IDLE: begin
          if (gap_cnt != 8'd0) begin
            gap_cnt <= gap_cnt - 8'd1;
          end else if (pop) begin
            keycode   <= mem[rd_ptr];
            irq       <= 1'b1;
            out_state <= OUT_HOLD;
          end
        end
        OUT_HOLD: begin
          if (clear_keycode) begin
            irq       <= 1'b0;
            keycode   <= 8'h00;
            gap_cnt   <= GAP_CYCLES;
            out_state <= OUT_IDLE;
          end
        end
        default: out_state <= OUT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !kbd_clock_low) begin
      hold_cnt <= 20'd0;
    end else if (hold_cnt != RESET_HOLD) begin
      hold_cnt <= hold_cnt + 20'd1;
    end
  end

endmodule
